// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and the
// stall/flush/redirect controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int addrWidth = 16
);
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 id_use_rs1;
    logic                 id_use_rs2;
    logic [4:0]           ex_rd;
    logic                 ex_mem_read;
    logic                 br_valid;
    logic                 br_taken;
    logic                 br_pred;
    logic [addrWidth-1:0] br_target;
    logic [addrWidth-1:0] br_pc_plus4;
    logic                 imem_ready;
    logic                 mem_op;
    logic                 dmem_ready;

    logic                 stall_pc;
    logic                 stall_id;
    logic                 flush_id;
    logic                 stall_ex;
    logic                 flush_ex;
    logic                 stall_mem;
    logic                 redirect_valid;
    logic [addrWidth-1:0] redirect_pc;
    logic [15:0]          mispredict_cnt;
    logic [15:0]          stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               br_valid, br_taken, br_pred, br_target, br_pc_plus4,
               imem_ready, mem_op, dmem_ready,
        input  stall_pc, stall_id, flush_id, stall_ex, flush_ex, stall_mem,
               redirect_valid, redirect_pc, mispredict_cnt, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               br_valid, br_taken, br_pred, br_target, br_pc_plus4,
               imem_ready, mem_op, dmem_ready,
        output stall_pc, stall_id, flush_id, stall_ex, flush_ex, stall_mem,
               redirect_valid, redirect_pc, mispredict_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage pipeline, with a
// pending-redirect register for fetches that are not ready and perf counters.
module pipe_hazard_ctrl #(
    parameter int addrWidth = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, MEM_BUSY} state_t;

    state_t               state, state_nx;
    logic                 pend_v;
    logic [addrWidth-1:0] pend_pc;
    logic [15:0]          misp_q, stall_q;

    logic                 dstall, mispredict, loaduse, ifwait;
    logic                 rs1_hit, rs2_hit;
    logic [addrWidth-1:0] target;
    logic                 stall_pc_w;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:      if (hz.mem_op && !hz.dmem_ready) state_nx = MEM_BUSY;
            MEM_BUSY: if (hz.dmem_ready)               state_nx = RUN;
            default:  state_nx = RUN;
        endcase
    end

    // Hazard terms, each already masked by the higher-priority ones.
    always_comb begin
        dstall     = ((state == RUN) && hz.mem_op && !hz.dmem_ready)
                  || ((state == MEM_BUSY) && !hz.dmem_ready);
        mispredict = hz.br_valid && (hz.br_taken != hz.br_pred) && !dstall;
        target     = hz.br_taken ? hz.br_target : hz.br_pc_plus4;
        rs1_hit    = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
        rs2_hit    = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
        loaduse    = hz.ex_mem_read && (hz.ex_rd != 5'd0) && (rs1_hit || rs2_hit)
                  && !dstall && !mispredict;
        ifwait     = !hz.imem_ready && !dstall;
        stall_pc_w = dstall || loaduse || ifwait;
    end

    always_comb begin
        hz.stall_pc       = 1'b0;
        hz.stall_id       = 1'b0;
        hz.flush_id       = 1'b0;
        hz.stall_ex       = 1'b0;
        hz.flush_ex       = 1'b0;
        hz.stall_mem      = 1'b0;
        hz.redirect_valid = 1'b0;
        hz.redirect_pc    = '0;
        hz.mispredict_cnt = '0;
        hz.stall_cnt      = '0;
        if (!rst) begin
            hz.stall_pc       = stall_pc_w;
            hz.stall_id       = dstall || loaduse;
            hz.stall_ex       = dstall;
            hz.stall_mem      = dstall;
            // A load-use stall holds IF/ID, so a fetch bubble must not flush it.
            hz.flush_id       = !dstall && (mispredict || pend_v || (ifwait && !loaduse));
            hz.flush_ex       = !dstall && (mispredict || loaduse);
            hz.redirect_valid = mispredict || pend_v;
            if (mispredict)  hz.redirect_pc = target;
            else if (pend_v) hz.redirect_pc = pend_pc;
            hz.mispredict_cnt = misp_q;
            hz.stall_cnt      = stall_q;
        end
    end

    // Redirect is held until a fetch actually completes outside a data stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v  <= 1'b0;
            pend_pc <= '0;
            misp_q  <= '0;
            stall_q <= '0;
        end else begin
            if (!dstall) begin
                if (mispredict && !hz.imem_ready) begin
                    pend_v  <= 1'b1;
                    pend_pc <= target;
                end else if (hz.imem_ready) begin
                    pend_v  <= 1'b0;
                end
            end
            if (mispredict) misp_q  <= misp_q + 16'd1;
            if (stall_pc_w) stall_q <= stall_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, multi-cycle sequences,
// and randomized cycles checked against a priority-rule reference model.
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic [4:0]  id_rs1;
        logic [4:0]  id_rs2;
        logic        id_use_rs1;
        logic        id_use_rs2;
        logic [4:0]  ex_rd;
        logic        ex_mem_read;
        logic        br_valid;
        logic        br_taken;
        logic        br_pred;
        logic [15:0] br_target;
        logic [15:0] br_pc_plus4;
        logic        imem_ready;
        logic        mem_op;
        logic        dmem_ready;
    } in_t;

    typedef struct {
        in_t         in;
        logic [22:0] exp;
        logic [15:0] sc;
        logic [15:0] mc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tab[$];

    pipe_hazard_ctrl_if #(.addrWidth(16)) bus();
    pipe_hazard_ctrl #(.addrWidth(16)) dut (.clk(clk), .rst(rst), .hz(bus));

    always #5 clk = ~clk;

    // Reference-model state.
    logic        m_busy, m_pv;
    logic [15:0] m_ppc, m_mc, m_sc;

    function automatic in_t idle();
        in_t v = '0;
        v.imem_ready = 1'b1;
        v.dmem_ready = 1'b1;
        return v;
    endfunction

    function automatic in_t f_lu(logic u1, logic [4:0] r1, logic u2, logic [4:0] r2, logic [4:0] rd);
        in_t v = idle();
        v.id_use_rs1 = u1; v.id_rs1 = r1;
        v.id_use_rs2 = u2; v.id_rs2 = r2;
        v.ex_rd = rd; v.ex_mem_read = 1'b1;
        return v;
    endfunction

    function automatic in_t f_br(logic tk, logic pr, logic [15:0] tgt, logic [15:0] pc4);
        in_t v = idle();
        v.br_valid = 1'b1; v.br_taken = tk; v.br_pred = pr;
        v.br_target = tgt; v.br_pc_plus4 = pc4;
        return v;
    endfunction

    function automatic logic [22:0] ex(logic sp, logic sid, logic fid, logic sex,
                                       logic fex, logic smem, logic rv, logic [15:0] rpc);
        return {sp, sid, fid, sex, fex, smem, rv, rpc};
    endfunction

    function automatic void add(in_t v, logic [22:0] e, logic [15:0] sc, logic [15:0] mc);
        vec_t t;
        t.in = v; t.exp = e; t.sc = sc; t.mc = mc;
        tab.push_back(t);
    endfunction

    task automatic drive(input in_t v);
        bus.id_rs1 = v.id_rs1;         bus.id_rs2 = v.id_rs2;
        bus.id_use_rs1 = v.id_use_rs1; bus.id_use_rs2 = v.id_use_rs2;
        bus.ex_rd = v.ex_rd;           bus.ex_mem_read = v.ex_mem_read;
        bus.br_valid = v.br_valid;     bus.br_taken = v.br_taken;
        bus.br_pred = v.br_pred;       bus.br_target = v.br_target;
        bus.br_pc_plus4 = v.br_pc_plus4;
        bus.imem_ready = v.imem_ready; bus.mem_op = v.mem_op;
        bus.dmem_ready = v.dmem_ready;
    endtask

    function automatic logic [22:0] outs();
        return {bus.stall_pc, bus.stall_id, bus.flush_id, bus.stall_ex,
                bus.flush_ex, bus.stall_mem, bus.redirect_valid, bus.redirect_pc};
    endfunction

    function automatic logic [31:0] cnts();
        return {bus.stall_cnt, bus.mispredict_cnt};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(idle());
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_cnts", cnts(), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    // Model: outcome chosen by hazard priority, written from the rules directly.
    function automatic logic [22:0] model_out(in_t v, logic r);
        logic        ds, hit, wrong;
        logic [15:0] tgt, ppc;
        if (r) return '0;
        ds    = (m_busy || v.mem_op) && !v.dmem_ready;
        hit   = v.ex_mem_read && v.ex_rd != 0 &&
                ((v.id_use_rs1 && v.id_rs1 == v.ex_rd) || (v.id_use_rs2 && v.id_rs2 == v.ex_rd));
        wrong = v.br_valid && (v.br_taken != v.br_pred);
        tgt   = v.br_taken ? v.br_target : v.br_pc_plus4;
        ppc   = m_pv ? m_ppc : 16'd0;
        if (ds)    return ex(1, 1, 0, 1, 0, 1, m_pv, ppc);
        if (wrong) return ex(!v.imem_ready, 0, 1, 0, 1, 0, 1, tgt);
        if (hit)   return ex(1, 1, m_pv, 0, 1, 0, m_pv, ppc);
        return ex(!v.imem_ready, 0, !v.imem_ready || m_pv, 0, 0, 0, m_pv, ppc);
    endfunction

    task automatic model_step(input in_t v, input logic r, input logic [22:0] o);
        logic ds, wrong;
        if (r) begin
            m_busy = 0; m_pv = 0; m_ppc = 0; m_mc = 0; m_sc = 0;
        end else begin
            ds    = (m_busy || v.mem_op) && !v.dmem_ready;
            wrong = v.br_valid && (v.br_taken != v.br_pred);
            if (!ds) begin
                if (wrong && !v.imem_ready) begin
                    m_pv = 1; m_ppc = v.br_taken ? v.br_target : v.br_pc_plus4;
                end else if (v.imem_ready) begin
                    m_pv = 0;
                end
            end
            if (wrong && !ds) m_mc = m_mc + 16'd1;
            if (o[22])        m_sc = m_sc + 16'd1;
            m_busy = ds;
        end
    endtask

    initial begin
        in_t v;
        logic [22:0] e;
        logic r;

        drive(idle());
        tick();

        add(f_lu(0, 0, 1, 5, 5), ex(1, 1, 0, 0, 1, 0, 0, 0), 1, 0);
        add(f_lu(0, 0, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        add(f_lu(0, 5, 0, 0, 5), ex(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        add(f_lu(1, 7, 0, 0, 7), ex(1, 1, 0, 0, 1, 0, 0, 0), 1, 0);
        add(f_lu(1, 3, 1, 4, 5), ex(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        add(f_br(1, 0, 16'h0040, 16'h0044), ex(0, 0, 1, 0, 1, 0, 1, 16'h0040), 0, 1);
        add(f_br(1, 1, 16'h0040, 16'h0044), ex(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        add(f_br(0, 0, 16'h0040, 16'h0044), ex(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        add(f_br(0, 1, 16'h0200, 16'h0104), ex(0, 0, 1, 0, 1, 0, 1, 16'h0104), 0, 1);
        v = f_br(1, 0, 16'h0040, 16'h0044); v.br_valid = 0;
        add(v, ex(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        v = idle(); v.imem_ready = 0;
        add(v, ex(1, 0, 1, 0, 0, 0, 0, 0), 1, 0);
        v = f_lu(0, 0, 1, 5, 5); v.imem_ready = 0;
        add(v, ex(1, 1, 0, 0, 1, 0, 0, 0), 1, 0);
        v = f_lu(0, 0, 1, 5, 5);
        v.br_valid = 1; v.br_taken = 1; v.br_pred = 0; v.br_target = 16'h0040;
        add(v, ex(0, 0, 1, 0, 1, 0, 1, 16'h0040), 0, 1);
        v.mem_op = 1; v.dmem_ready = 0;
        add(v, ex(1, 1, 0, 1, 0, 1, 0, 0), 1, 0);
        v = idle(); v.mem_op = 1;
        add(v, ex(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);

        foreach (tab[i]) begin
            do_reset();
            drive(tab[i].in);
            @(negedge clk);
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tab[i].exp));
            tick();
            drive(idle());
            @(negedge clk);
            check($sformatf("vec%0d_after", i), 32'(outs()), 32'd0);
            check($sformatf("vec%0d_cnts", i), cnts(), {tab[i].sc, tab[i].mc});
            tick();
        end

        // Mispredict while fetch waits: redirect held until fetch completes.
        do_reset();
        v = f_br(0, 1, 16'h0200, 16'h0104); v.imem_ready = 0;
        drive(v);
        @(negedge clk);
        check("pend_c0", 32'(outs()), 32'(ex(1, 0, 1, 0, 1, 0, 1, 16'h0104)));
        tick();
        v = idle(); v.imem_ready = 0;
        for (int k = 1; k <= 2; k++) begin
            drive(v);
            @(negedge clk);
            check($sformatf("pend_c%0d", k), 32'(outs()), 32'(ex(1, 0, 1, 0, 0, 0, 1, 16'h0104)));
            tick();
        end
        drive(idle());
        @(negedge clk);
        check("pend_c3", 32'(outs()), 32'(ex(0, 0, 1, 0, 0, 0, 1, 16'h0104)));
        tick();
        @(negedge clk);
        check("pend_clear", 32'(outs()), 32'd0);
        check("pend_cnts", cnts(), {16'd3, 16'd1});
        tick();

        // Data-memory stall freezes a mispredicting branch until dmem_ready.
        do_reset();
        v = f_br(1, 0, 16'h0040, 16'h0044); v.mem_op = 1; v.dmem_ready = 0;
        for (int k = 0; k < 4; k++) begin
            drive(v);
            @(negedge clk);
            check($sformatf("dstall_c%0d", k), 32'(outs()), 32'(ex(1, 1, 0, 1, 0, 1, 0, 0)));
            tick();
        end
        v.dmem_ready = 1;
        drive(v);
        @(negedge clk);
        check("dstall_release", 32'(outs()), 32'(ex(0, 0, 1, 0, 1, 0, 1, 16'h0040)));
        tick();
        drive(idle());
        @(negedge clk);
        check("dstall_cnts", cnts(), {16'd4, 16'd1});
        tick();

        // Reset while MEM_BUSY with a pending redirect discards both.
        do_reset();
        v = f_br(0, 1, 16'h0200, 16'h0104); v.imem_ready = 0;
        drive(v);
        tick();
        v = idle(); v.mem_op = 1; v.dmem_ready = 0;
        drive(v);
        tick();
        rst = 1;
        v.br_valid = 1; v.br_taken = 1; v.br_pred = 0;
        drive(v);
        @(negedge clk);
        check("rst_busy_outs", 32'(outs()), 32'd0);
        check("rst_busy_cnts", cnts(), 32'd0);
        tick();
        rst = 0;
        v = idle(); v.dmem_ready = 0;
        drive(v);
        @(negedge clk);
        check("post_rst_outs", 32'(outs()), 32'd0);
        check("post_rst_cnts", cnts(), 32'd0);
        tick();

        // Randomized cycles against the reference model.
        do_reset();
        m_busy = 0; m_pv = 0; m_ppc = 0; m_mc = 0; m_sc = 0;
        for (int n = 0; n < 2000; n++) begin
            v.id_rs1      = 5'($urandom_range(0, 3));
            v.id_rs2      = 5'($urandom_range(0, 3));
            v.id_use_rs1  = 1'($urandom);
            v.id_use_rs2  = 1'($urandom);
            v.ex_rd       = 5'($urandom_range(0, 3));
            v.ex_mem_read = 1'($urandom);
            v.br_valid    = ($urandom_range(0, 3) == 0);
            v.br_taken    = 1'($urandom);
            v.br_pred     = 1'($urandom);
            v.br_target   = 16'($urandom);
            v.br_pc_plus4 = 16'($urandom);
            v.imem_ready  = ($urandom_range(0, 3) != 0);
            v.mem_op      = 1'($urandom);
            v.dmem_ready  = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 63) == 0);
            rst = r;
            drive(v);
            @(negedge clk);
            e = model_out(v, r);
            check($sformatf("rand%0d_outs", n), 32'(outs()), 32'(e));
            check($sformatf("rand%0d_cnts", n), cnts(), r ? 32'd0 : {m_sc, m_mc});
            tick();
            model_step(v, r, e);
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
